cu_sequencer: RTL
=================

# cu_sequencer

Parametrised, self-sequencing control unit for the Complex CPU. It owns the binary-encoded micro-state register, the fetch/dispatch step logic, the per-step control word and unified conditional-branch evaluation. It also owns a memory wait-state handshake with a bus watchdog. It sits between the IR/flag outputs of the datapath and every load strobe, bus mux and ALU select in the datapath.

## Interface
Parameters:
- OPCODE_W, 5: opcode field width; codes ≥16 are illegal.
- COND_W, 3: branch condition field width.
- SEL_W, 4: SYSTEMBUSSEL width (0 PC, 1 DR, 2 AR, 3 AC, 4 MEM, 5 TR, 6 rop1, 7 rop2, 8 GPR1).
- ALU_W, 3: ALUSEL width (0 add, 1 sub, 2 mul, 3 lsr, 4 and, 5 or, 6 mvn).
- WDOG_W, 8: bus watchdog counter width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  OPCODE_W  IR opcode field.
- cond  in  COND_W  IR condition field; used by branch only.
- N, Z, C, V  in  1 each  ALU flags.
- mem_ready  in  1  memory accepts or returns data this cycle.
- irq  in  1  level interrupt request; only with CU_IRQ_EN.
- load_en  out  11  {RSEL,ROP1,ROP2,TR,AR,PC,DR,AC,IR,GPR,MEM}LOAD, bit 10..0.
- PCINC, COUNTER-free: PCINC  out  1  PC increment.
- ALUSEL  out  ALU_W  ALU operation.
- SYSTEMBUSSEL  out  SEL_W  bus source.
- mem_req  out  1  memory access pending.
- instr_done  out  1  one-cycle pulse on the last step of every instruction.
- ill_op  out  1  one-cycle pulse when an illegal opcode is dispatched.
- bus_err  out  1  sticky; set by watchdog expiry, cleared by reset only.
- state  out  6  current micro-state, for debug.

## Operation
- The step sequence, control word and step count per instruction follow the 40-step ISA microcode. Opcode map: 0 nop, 1 mov, 2 ALTmov, 3 ldr, 4 ALTldr, 5 str, 6 ALTstr, 7 cmp, 8 b, 9 add, 10 sub, 11 mul, 12 lsr, 13 and, 14 or, 15 mvn.
- FETCH1 (AR←PC) → FETCH2 (DR←MEM, PCINC) → FETCH3 (IR, RSEL, ROP1, ROP2 ←DR; dispatch). The next state is the routine start for `opcode`.
- Illegal opcode: ill_op pulses in FETCH3, a single NOP step executes, then FETCH1.
- Unified branch `b`: a single step drives SYSTEMBUSSEL=7. PCLOAD=1 iff the condition holds:
  - 0 AL
  - 1 EQ (Z)
  - 2 NE (!Z)
  - 3 GT (!Z & N==V)
  - 4 LT (N!=V)
  - 5 GE (N==V)
  - 6 LE (Z | N!=V)
  - 7 NV
- The last step of every routine returns to FETCH1 and pulses instr_done. Values are all driven from the state register and inputs; there is no latch on unreachable states.
- Unreachable state codes decode to an all-zero control word and go to FETCH1 next cycle.

## Timing
- Reset (asynchronous): state=FETCH1, bus_err=0, watchdog=0. While rst=1, all outputs are forced to 0.
- Memory steps FETCH2, ALTldr3, str4 and ALTstr4 assert mem_req and hold their state until mem_ready=1.
  - DRLOAD/MEMLOAD/PCINC are asserted only in the cycle mem_ready=1; the state advances on that edge.
  - Zero wait states means a 1-cycle step.
- Watchdog: counts cycles spent waiting in a memory step and clears on step exit. When it reaches 2^WDOG_W−1 without mem_ready:
  - bus_err is set;
  - the access is aborted with no load strobe;
  - the next state is FETCH1.
- mem_ready outside memory steps is ignored.
- Instruction latency with zero waits:
  - nop/mov/cmp/b: 4 cycles
  - ALTmov/ldr/arith: 5 cycles
  - ALTldr/str/ALTstr: 7 cycles

## Configuration
- CU_IRQ_EN defined:
  - At any instr_done with irq=1, the next state is IRQ1 (TR←PC) → IRQ2 (PCLOAD from vector constant 0, bus sel 0 forced zero) → FETCH1. instr_done does not pulse in IRQ steps.
  - irq is sampled only at instruction boundaries.
- CU_IRQ_EN undefined: the irq port is absent and the IRQ states do not exist.

## Test plan
- Reset mid-FETCH2 with mem_req high → next cycle state=FETCH1, all outputs 0, bus_err=0.
- add (opcode 9), mem_ready tied 1 → FETCH1..3, add1 (ACLOAD, ALUSEL=0), add2 (GPRLOAD, bus 3), instr_done at cycle 5.
- b with cond=3, flags Z=0 N=1 V=1 → PCLOAD=1; repeat with N=1 V=0 → PCLOAD=0. Both take 4 cycles.
- str with mem_ready delayed 3 cycles in str4 → MEMLOAD only in the ready cycle, total 10 cycles.
- mem_ready never asserted in FETCH2, WDOG_W=4 → bus_err set after 15 wait cycles, state=FETCH1, no DRLOAD.
- opcode 20 → ill_op pulse in FETCH3, one NOP step, then FETCH1. With CU_IRQ_EN and irq=1: IRQ1, IRQ2, then PC=0.

Source files
------------

// File: rtl/cu_sequencer.sv
`default_nettype none
// cu_sequencer: micro-sequenced control unit (fetch/dispatch, control word, branch
// condition, memory wait-state handshake with bus watchdog). Optional IRQ entry: CU_IRQ_EN.
module cu_sequencer #(
  parameter int OPCODE_W = 5,
  parameter int COND_W   = 3,
  parameter int SEL_W    = 4,
  parameter int ALU_W    = 3,
  parameter int WDOG_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [COND_W-1:0]   cond,
  input  logic                N,
  input  logic                Z,
  input  logic                C,
  input  logic                V,
  input  logic                mem_ready,
`ifdef CU_IRQ_EN
  input  logic                irq,
`endif
  output logic [10:0]         load_en,
  output logic                PCINC,
  output logic [ALU_W-1:0]    ALUSEL,
  output logic [SEL_W-1:0]    SYSTEMBUSSEL,
  output logic                mem_req,
  output logic                instr_done,
  output logic                ill_op,
  output logic                bus_err,
  output logic [5:0]          state
);

  localparam int LD_RSEL = 10, LD_ROP1 = 9, LD_ROP2 = 8, LD_TR = 7, LD_AR = 6, LD_PC = 5;
  localparam int LD_DR = 4, LD_AC = 3, LD_IR = 2, LD_GPR = 1, LD_MEM = 0;

  localparam logic [SEL_W-1:0] BUS_PC   = SEL_W'(0);
  localparam logic [SEL_W-1:0] BUS_DR   = SEL_W'(1);
  localparam logic [SEL_W-1:0] BUS_AC   = SEL_W'(3);
  localparam logic [SEL_W-1:0] BUS_MEM  = SEL_W'(4);
  localparam logic [SEL_W-1:0] BUS_TR   = SEL_W'(5);
  localparam logic [SEL_W-1:0] BUS_ROP1 = SEL_W'(6);
  localparam logic [SEL_W-1:0] BUS_ROP2 = SEL_W'(7);
  localparam logic [SEL_W-1:0] BUS_GPR1 = SEL_W'(8);

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_MUL = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_LSR = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(4);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(5);
  localparam logic [ALU_W-1:0] ALU_MVN = ALU_W'(6);

  // Last count value seen before the watchdog would reach all-ones.
  localparam logic [WDOG_W-1:0] WDOG_EXP = {{(WDOG_W-1){1'b1}}, 1'b0};

  typedef enum logic [5:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_NOP1, S_MOV1, S_AMOV1, S_AMOV2, S_LDR1, S_LDR2,
    S_ALDR1, S_ALDR2, S_ALDR3, S_ALDR4, S_STR1, S_STR2, S_STR3, S_STR4,
    S_ASTR1, S_ASTR2, S_ASTR3, S_ASTR4, S_CMP1, S_B1,
    S_ADD1, S_ADD2, S_SUB1, S_SUB2, S_MUL1, S_MUL2, S_LSR1, S_LSR2,
    S_AND1, S_AND2, S_ORR1, S_ORR2, S_MVN1, S_MVN2
`ifdef CU_IRQ_EN
    , S_IRQ1, S_IRQ2
`endif
  } state_t;

  state_t              st;
  state_t              route;
  state_t              dispatch;
  logic [WDOG_W-1:0]   wdog;
  logic                bus_err_r;
  logic [10:0]         ld;
  logic                pcinc;
  logic [ALU_W-1:0]    alu;
  logic [SEL_W-1:0]    bus;
  logic                mem_step;
  logic                last;
  logic                ill;
  logic                illegal;
  logic                taken;
  logic                advance;
  logic                unused_c;

  assign unused_c = C;

  always_comb begin
    taken = 1'b0;
    case (int'(cond))
      0:       taken = 1'b1;
      1:       taken = Z;
      2:       taken = !Z;
      3:       taken = !Z && (N == V);
      4:       taken = (N != V);
      5:       taken = (N == V);
      6:       taken = Z || (N != V);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    dispatch = S_NOP1;
    illegal  = 1'b0;
    case (int'(opcode))
      0:       dispatch = S_NOP1;
      1:       dispatch = S_MOV1;
      2:       dispatch = S_AMOV1;
      3:       dispatch = S_LDR1;
      4:       dispatch = S_ALDR1;
      5:       dispatch = S_STR1;
      6:       dispatch = S_ASTR1;
      7:       dispatch = S_CMP1;
      8:       dispatch = S_B1;
      9:       dispatch = S_ADD1;
      10:      dispatch = S_SUB1;
      11:      dispatch = S_MUL1;
      12:      dispatch = S_LSR1;
      13:      dispatch = S_AND1;
      14:      dispatch = S_ORR1;
      15:      dispatch = S_MVN1;
      default: illegal  = 1'b1;
    endcase
  end

  always_comb begin
    ld       = '0;
    pcinc    = 1'b0;
    alu      = ALU_ADD;
    bus      = BUS_PC;
    mem_step = 1'b0;
    last     = 1'b0;
    ill      = 1'b0;
    route    = S_FETCH1;
    case (st)
      S_FETCH1: begin ld[LD_AR] = 1'b1; route = S_FETCH2; end
      S_FETCH2: begin
        ld[LD_DR] = 1'b1; pcinc = 1'b1; bus = BUS_MEM; mem_step = 1'b1; route = S_FETCH3;
      end
      S_FETCH3: begin
        ld[LD_IR] = 1'b1; ld[LD_RSEL] = 1'b1; ld[LD_ROP1] = 1'b1; ld[LD_ROP2] = 1'b1;
        bus = BUS_DR; ill = illegal; route = dispatch;
      end
      S_NOP1:  last = 1'b1;
      S_MOV1:  begin ld[LD_GPR] = 1'b1; bus = BUS_ROP2; last = 1'b1; end
      S_AMOV1: begin ld[LD_TR] = 1'b1; bus = BUS_ROP2; route = S_AMOV2; end
      S_AMOV2: begin ld[LD_GPR] = 1'b1; bus = BUS_TR; last = 1'b1; end
      S_LDR1:  begin ld[LD_AR] = 1'b1; bus = BUS_ROP2; route = S_LDR2; end
      S_LDR2:  begin ld[LD_GPR] = 1'b1; bus = BUS_MEM; last = 1'b1; end
      S_ALDR1: begin ld[LD_AR] = 1'b1; bus = BUS_ROP2; route = S_ALDR2; end
      S_ALDR2: begin ld[LD_TR] = 1'b1; bus = BUS_ROP1; route = S_ALDR3; end
      S_ALDR3: begin ld[LD_DR] = 1'b1; bus = BUS_MEM; mem_step = 1'b1; route = S_ALDR4; end
      S_ALDR4: begin ld[LD_GPR] = 1'b1; bus = BUS_DR; last = 1'b1; end
      S_STR1:  begin ld[LD_AR] = 1'b1; bus = BUS_ROP2; route = S_STR2; end
      S_STR2:  begin ld[LD_TR] = 1'b1; bus = BUS_GPR1; route = S_STR3; end
      S_STR3:  begin ld[LD_DR] = 1'b1; bus = BUS_TR; route = S_STR4; end
      S_STR4:  begin ld[LD_MEM] = 1'b1; bus = BUS_DR; mem_step = 1'b1; last = 1'b1; end
      S_ASTR1: begin ld[LD_AR] = 1'b1; bus = BUS_ROP1; route = S_ASTR2; end
      S_ASTR2: begin ld[LD_TR] = 1'b1; bus = BUS_ROP2; route = S_ASTR3; end
      S_ASTR3: begin ld[LD_DR] = 1'b1; bus = BUS_TR; route = S_ASTR4; end
      S_ASTR4: begin ld[LD_MEM] = 1'b1; bus = BUS_DR; mem_step = 1'b1; last = 1'b1; end
      S_CMP1:  begin alu = ALU_SUB; last = 1'b1; end
      S_B1:    begin ld[LD_PC] = taken; bus = BUS_ROP2; last = 1'b1; end
      S_ADD1:  begin ld[LD_AC] = 1'b1; alu = ALU_ADD; route = S_ADD2; end
      S_SUB1:  begin ld[LD_AC] = 1'b1; alu = ALU_SUB; route = S_SUB2; end
      S_MUL1:  begin ld[LD_AC] = 1'b1; alu = ALU_MUL; route = S_MUL2; end
      S_LSR1:  begin ld[LD_AC] = 1'b1; alu = ALU_LSR; route = S_LSR2; end
      S_AND1:  begin ld[LD_AC] = 1'b1; alu = ALU_AND; route = S_AND2; end
      S_ORR1:  begin ld[LD_AC] = 1'b1; alu = ALU_OR;  route = S_ORR2; end
      S_MVN1:  begin ld[LD_AC] = 1'b1; alu = ALU_MVN; route = S_MVN2; end
      S_ADD2, S_SUB2, S_MUL2, S_LSR2, S_AND2, S_ORR2, S_MVN2: begin
        ld[LD_GPR] = 1'b1; bus = BUS_AC; last = 1'b1;
      end
`ifdef CU_IRQ_EN
      S_IRQ1:  begin ld[LD_TR] = 1'b1; bus = BUS_PC; route = S_IRQ2; end
      S_IRQ2:  begin ld[LD_PC] = 1'b1; bus = BUS_PC; end
`endif
      default: ;
    endcase
  end

  // Memory steps only strobe loads and retire in the cycle the bus answers.
  assign advance = !mem_step || mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_FETCH1;
      wdog      <= '0;
      bus_err_r <= 1'b0;
    end else if (mem_step && !mem_ready) begin
      if (wdog == WDOG_EXP) begin
        bus_err_r <= 1'b1;
        wdog      <= '0;
        st        <= S_FETCH1;
      end else begin
        wdog <= wdog + WDOG_W'(1);
      end
    end else begin
      wdog <= '0;
`ifdef CU_IRQ_EN
      st   <= (last && irq) ? S_IRQ1 : route;
`else
      st   <= route;
`endif
    end
  end

  assign load_en      = (rst || !advance) ? 11'd0 : ld;
  assign PCINC        = !rst && advance && pcinc;
  assign ALUSEL       = rst ? '0 : alu;
  assign SYSTEMBUSSEL = rst ? '0 : bus;
  assign mem_req      = !rst && mem_step;
  assign instr_done   = !rst && last && advance;
  assign ill_op       = !rst && ill;
  assign bus_err      = !rst && bus_err_r;
  assign state        = rst ? 6'd0 : st;

endmodule
`default_nettype wire
